pipeline_ctrl: RTL

Central hazard and stall controller for the 5-stage ARM pipeline.
- Detects RAW hazards between the ID stage and the EX/MEM stages, with or without forwarding.
- Issues branch flushes.
- Sequences a multi-cycle SRAM wait that freezes the whole pipeline.
- Drives flush/freeze of the IF/ID and ID/EX registers and the PC, and keeps saturating stall/flush performance counters.

---
 rtl/pipeline_ctrl_if.sv | 40 ++++
 rtl/pipeline_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall controller bundle: ID/EX/MEM hazard sources in, pipeline
// control and performance counters out.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       src1_i;
    logic [3:0]       src2_i;
    logic             two_src_i;
    logic             id_valid_i;
    logic [3:0]       exe_dest_i;
    logic             exe_wb_en_i;
    logic             exe_mem_r_en_i;
    logic [3:0]       mem_dest_i;
    logic             mem_wb_en_i;
    logic             mem_req_i;
    logic             fwd_en_i;
    logic             branch_taken_i;
    logic             hazard_o;
    logic             if_flush_o;
    logic             id_flush_o;
    logic             freeze_all_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output src1_i, src2_i, two_src_i, id_valid_i, exe_dest_i, exe_wb_en_i,
               exe_mem_r_en_i, mem_dest_i, mem_wb_en_i, mem_req_i, fwd_en_i,
               branch_taken_i,
        input  hazard_o, if_flush_o, id_flush_o, freeze_all_o, stall_cnt_o,
               flush_cnt_o
    );

    modport slave (
        input  src1_i, src2_i, two_src_i, id_valid_i, exe_dest_i, exe_wb_en_i,
               exe_mem_r_en_i, mem_dest_i, mem_wb_en_i, mem_req_i, fwd_en_i,
               branch_taken_i,
        output hazard_o, if_flush_o, id_flush_o, freeze_all_o, stall_cnt_o,
               flush_cnt_o
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central hazard/stall controller for the 5-stage pipeline: RAW detection,
// branch flush, multi-cycle SRAM freeze sequencing and saturating perf counters.
module pipeline_ctrl #(
    parameter int MEM_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input logic           clk,
    input logic           rst,
    pipeline_ctrl_if.slave ctrl
);
    localparam int WCNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } memState_t;

    memState_t        state_q;
    logic [WCNT_W-1:0] waitCnt_q;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

    logic freezeReq;
    logic m1, m2, n1, n2, raw;
    logic hazard, ifFlush, idFlush, freezeAll;

    assign freezeReq = (MEM_WAIT != 0) && ctrl.mem_req_i;

    // Freeze dominates a taken branch, which dominates a RAW bubble; all quiet in reset.
    always_comb begin
        hazard    = 1'b0;
        ifFlush   = 1'b0;
        idFlush   = 1'b0;
        freezeAll = 1'b0;
        m1 = ctrl.id_valid_i & ctrl.exe_wb_en_i & (ctrl.src1_i == ctrl.exe_dest_i);
        m2 = ctrl.id_valid_i & ctrl.two_src_i & ctrl.exe_wb_en_i & (ctrl.src2_i == ctrl.exe_dest_i);
        n1 = ctrl.id_valid_i & ctrl.mem_wb_en_i & (ctrl.src1_i == ctrl.mem_dest_i);
        n2 = ctrl.id_valid_i & ctrl.two_src_i & ctrl.mem_wb_en_i & (ctrl.src2_i == ctrl.mem_dest_i);
        raw = ctrl.fwd_en_i ? (ctrl.exe_mem_r_en_i & (m1 | m2)) : (m1 | m2 | n1 | n2);
        if (rst) begin
            case (state_q)
                ST_RUN:  freezeAll = freezeReq;
                ST_WAIT: freezeAll = 1'b1;
                default: freezeAll = 1'b0;
            endcase
            if (!freezeAll) begin
                if (ctrl.branch_taken_i) begin
                    ifFlush = 1'b1;
                    idFlush = 1'b1;
                end else if (raw) begin
                    hazard  = 1'b1;
                    idFlush = 1'b1;
                end
            end
        end
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if ((hazard | freezeAll) && (stallCnt_q != '1))
            stallCnt_d = stallCnt_q + CNT_W'(1);
        if (ifFlush && (flushCnt_q != '1))
            flushCnt_d = flushCnt_q + CNT_W'(1);
    end

    // DONE never samples mem_req, so a finished access cannot re-trigger itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            waitCnt_q  <= '0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
            case (state_q)
                ST_RUN: begin
                    if (freezeReq) begin
                        if (MEM_WAIT == 1) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q   <= ST_WAIT;
                            waitCnt_q <= WCNT_W'(MEM_WAIT - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    waitCnt_q <= waitCnt_q - WCNT_W'(1);
                    if (waitCnt_q == WCNT_W'(1))
                        state_q <= ST_DONE;
                end
                ST_DONE: state_q <= ST_RUN;
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign ctrl.hazard_o     = hazard;
    assign ctrl.if_flush_o   = ifFlush;
    assign ctrl.id_flush_o   = idFlush;
    assign ctrl.freeze_all_o = freezeAll;
    assign ctrl.stall_cnt_o  = stallCnt_q;
    assign ctrl.flush_cnt_o  = flushCnt_q;
endmodule
